// File: rtl/cardiac_therapy_pkg.sv
// Shared types and defaults for the cardiac therapy sequencer.
// Holds the state enum, threshold/timing defaults and dose saturation.
package cardiac_therapy_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CPR,
    S_DRUG,
    S_FLUSH,
    S_CLOSE,
    S_LOCKOUT
  } state_e;

  localparam int HR_W_DEF        = 8;
  localparam int HR_LOW_DEF      = 50;
  localparam int HR_HIGH_DEF     = 120;
  localparam int SPO2_LOW_DEF    = 95;
  localparam int PERSIST_CYC_DEF = 4;
  localparam int DRUG_CYC_DEF    = 2;
  localparam int FLUSH_CYC_DEF   = 2;
  localparam int CLOSE_CYC_DEF   = 4;
  localparam int LOCKOUT_CYC_DEF = 8;
  localparam int DOSE_FIRST_DEF  = 6;
  localparam int DOSE_STEP_DEF   = 6;
  localparam int MAX_DOSES_DEF   = 2;

  // Escalated dose clamped to the 4-bit pump range.
  function automatic logic [3:0] dose_sat(
    input int first,
    input int step,
    input int count
  );
    int s;
    s = first + count * step;
    return (s > 15) ? 4'd15 : 4'(s);
  endfunction

endpackage

// File: rtl/persistence_filter.sv
// Consecutive-cycle qualifier: hit is high when cond has held for
// PERSIST_CYC cycles including the current one.
module persistence_filter
#(
  parameter int PERSIST_CYC = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic cond,
  output logic hit
);

  localparam int CW = $clog2(PERSIST_CYC + 1);
  localparam logic [CW-1:0] SAT  = CW'(PERSIST_CYC);
  localparam logic [CW-1:0] TRIG = CW'(PERSIST_CYC - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Saturating run length, cleared whenever the condition drops.
  always_comb begin
    cnt_d = '0;
    if (cond) begin
      cnt_d = (cnt_q == SAT) ? cnt_q : cnt_q + CW'(1);
    end
  end

  assign hit = cond && (cnt_q >= TRIG);

  // Run counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/cardiac_therapy_sequencer.sv
// Brady/tachy qualified CPR and drug-sequence controller.
// Optional macro CARDIAC_DOSE_ESCALATION_EN enables dose escalation.
module cardiac_therapy_sequencer
  import cardiac_therapy_pkg::*;
#(
  parameter int HR_W        = HR_W_DEF,
  parameter int HR_LOW      = HR_LOW_DEF,
  parameter int HR_HIGH     = HR_HIGH_DEF,
  parameter int SPO2_LOW    = SPO2_LOW_DEF,
  parameter int PERSIST_CYC = PERSIST_CYC_DEF,
  parameter int DRUG_CYC    = DRUG_CYC_DEF,
  parameter int FLUSH_CYC   = FLUSH_CYC_DEF,
  parameter int CLOSE_CYC   = CLOSE_CYC_DEF,
  parameter int LOCKOUT_CYC = LOCKOUT_CYC_DEF,
  parameter int DOSE_FIRST  = DOSE_FIRST_DEF,
  parameter int DOSE_STEP   = DOSE_STEP_DEF,
  parameter int MAX_DOSES   = MAX_DOSES_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [HR_W-1:0] heart_rate,
  input  logic [7:0]      oxygen_level,
  input  logic            ecg_signal_valid,
  output logic            cpr_activate,
  output logic            drug_delivery_activate,
  output logic [3:0]      drug_dosage,
  output logic            iv_line_setup,
  output logic            saline_flush,
  output logic [2:0]      dose_count,
  output logic            therapy_exhausted,
  output logic            seq_busy
);

  localparam int M1 = (DRUG_CYC > FLUSH_CYC) ? DRUG_CYC : FLUSH_CYC;
  localparam int M2 = (CLOSE_CYC > LOCKOUT_CYC) ? CLOSE_CYC : LOCKOUT_CYC;
  localparam int MAX_CYC = (M1 > M2) ? M1 : M2;
  localparam int SW = $clog2(MAX_CYC + 1);

  logic brady, tachy, brady_hit, tachy_hit, adv;
  logic [3:0] new_dose;

  state_e        state_q, state_d;
  logic [SW-1:0] stg_q, stg_d;
  logic [2:0]    cnt_q, cnt_d;
  logic          exh_q, exh_d;
  logic          cpr_q, cpr_d;
  logic          drug_q, drug_d;
  logic [3:0]    dose_q, dose_d;
  logic          iv_q, iv_d;
  logic          flush_q, flush_d;
  logic          busy_q, busy_d;

  assign brady = ecg_signal_valid
              && (heart_rate < HR_W'(HR_LOW))
              && (oxygen_level < 8'(SPO2_LOW));
  assign tachy = ecg_signal_valid
              && (heart_rate > HR_W'(HR_HIGH))
              && (oxygen_level >= 8'(SPO2_LOW));

  persistence_filter #(.PERSIST_CYC(PERSIST_CYC)) u_brady (
    .clk   (clk),
    .rst_n (rst_n),
    .cond  (brady),
    .hit   (brady_hit)
  );

  persistence_filter #(.PERSIST_CYC(PERSIST_CYC)) u_tachy (
    .clk   (clk),
    .rst_n (rst_n),
    .cond  (tachy),
    .hit   (tachy_hit)
  );

`ifdef CARDIAC_DOSE_ESCALATION_EN
  assign new_dose = dose_sat(DOSE_FIRST, DOSE_STEP, int'(cnt_q));
`else
  assign new_dose = 4'(DOSE_FIRST);
`endif

  assign adv = (stg_q == '0);

  // Next state, stage timer, dose bookkeeping and output decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    exh_d   = exh_q;
    if (brady_hit) begin
      state_d = S_CPR;
      cnt_d   = '0;
      exh_d   = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE:    if (tachy_hit && !exh_q) state_d = S_DRUG;
        S_CPR:     if (!brady) state_d = S_IDLE;
        S_DRUG: begin
          if (adv) begin
            state_d = S_FLUSH;
            cnt_d   = cnt_q + 3'd1;
          end
        end
        S_FLUSH:   if (adv) state_d = S_CLOSE;
        S_CLOSE: begin
          if (adv) begin
            state_d = S_LOCKOUT;
            if (cnt_q >= 3'(MAX_DOSES)) exh_d = 1'b1;
          end
        end
        S_LOCKOUT: if (adv) state_d = S_IDLE;
        default:   state_d = S_IDLE;
      endcase
    end

    stg_d = adv ? stg_q : stg_q - SW'(1);
    if (state_d != state_q) begin
      unique case (state_d)
        S_DRUG:    stg_d = SW'(DRUG_CYC - 1);
        S_FLUSH:   stg_d = SW'(FLUSH_CYC - 1);
        S_CLOSE:   stg_d = SW'(CLOSE_CYC - 1);
        S_LOCKOUT: stg_d = SW'(LOCKOUT_CYC - 1);
        default:   stg_d = '0;
      endcase
    end

    cpr_d   = (state_d == S_CPR);
    drug_d  = (state_d == S_DRUG);
    flush_d = (state_d == S_FLUSH);
    iv_d    = drug_d || flush_d || (state_d == S_CLOSE);
    busy_d  = (state_d != S_IDLE);
    dose_d  = '0;
    if (drug_d) begin
      dose_d = (state_q == S_DRUG) ? dose_q : new_dose;
    end
  end

  // FSM state and registered actuator drives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      stg_q   <= '0;
      cnt_q   <= '0;
      exh_q   <= 1'b0;
      cpr_q   <= 1'b0;
      drug_q  <= 1'b0;
      dose_q  <= '0;
      iv_q    <= 1'b0;
      flush_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      stg_q   <= stg_d;
      cnt_q   <= cnt_d;
      exh_q   <= exh_d;
      cpr_q   <= cpr_d;
      drug_q  <= drug_d;
      dose_q  <= dose_d;
      iv_q    <= iv_d;
      flush_q <= flush_d;
      busy_q  <= busy_d;
    end
  end

  assign cpr_activate           = cpr_q;
  assign drug_delivery_activate = drug_q;
  assign drug_dosage            = dose_q;
  assign iv_line_setup          = iv_q;
  assign saline_flush           = flush_q;
  assign dose_count             = cnt_q;
  assign therapy_exhausted      = exh_q;
  assign seq_busy               = busy_q;

endmodule

// File: doc/cardiac_therapy_sequencer.md
# cardiac_therapy_sequencer

Parametrised successor to the single-cycle heart monitor. It qualifies bradycardia and tachycardia over a configurable number of consecutive cycles, then runs CPR or a timed adenosine/saline/IV-close sequence under a state machine. Bounded repeat dosing and a post-dose lockout are included. All timing uses counters; there are no behavioural delays. It sits between the vital-sign front end and the actuator drivers.

## Interface
- HR_W, 8: heart_rate width.
- HR_LOW, 50: bradycardia threshold; condition is heart_rate < HR_LOW.
- HR_HIGH, 120: tachycardia threshold; condition is heart_rate > HR_HIGH.
- SPO2_LOW, 95: oxygen threshold.
- PERSIST_CYC, 4: consecutive qualifying cycles needed to trigger (≥1).
- DRUG_CYC, 2: cycles in DRUG (≥1).
- FLUSH_CYC, 2: cycles in FLUSH (≥1).
- CLOSE_CYC, 4: cycles in CLOSE (≥1).
- LOCKOUT_CYC, 8: cycles in LOCKOUT (≥1).
- DOSE_FIRST, 6: first dose in mg (4-bit).
- DOSE_STEP, 6: escalation step in mg.
- MAX_DOSES, 2: doses allowed per episode (1–7).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- heart_rate  in  HR_W  bpm.
- oxygen_level  in  8  SpO2 %.
- ecg_signal_valid  in  1  ECG valid flag.
- cpr_activate  out  1  CPR drive.
- drug_delivery_activate  out  1  drug pump drive.
- drug_dosage  out  4  dose in mg; nonzero only in DRUG.
- iv_line_setup  out  1  IV line open.
- saline_flush  out  1  saline flush drive.
- dose_count  out  3  doses delivered this episode.
- therapy_exhausted  out  1  MAX_DOSES reached.
- seq_busy  out  1  state is not IDLE.

## Operation
- Qualifiers:
  - brady = ecg_signal_valid && heart_rate < HR_LOW && oxygen_level < SPO2_LOW.
  - tachy = ecg_signal_valid && heart_rate > HR_HIGH && oxygen_level >= SPO2_LOW.
  - Each qualifier has its own saturating run counter. The counter clears on any cycle its condition is false.
  - brady_q / tachy_q assert when the counter has reached PERSIST_CYC.
- States: IDLE, CPR, DRUG, FLUSH, CLOSE, LOCKOUT.
- Transitions:
  - Any state → CPR when brady_q. This has highest priority, preempts the drug sequence, clears dose_count, and clears therapy_exhausted.
  - CPR → IDLE on the first cycle brady is false.
  - IDLE → DRUG when tachy_q && !therapy_exhausted.
  - DRUG → FLUSH, FLUSH → CLOSE, CLOSE → LOCKOUT, LOCKOUT → IDLE: each transition occurs after that state's *_CYC cycles.
  - On entering DRUG, latch the dose. dose_count increments on DRUG → FLUSH.
  - If dose_count reaches MAX_DOSES, therapy_exhausted sets on CLOSE → LOCKOUT.
- Outputs are registered and decoded from the next state, so they change on the same edge as the state:
  - CPR: cpr_activate = 1.
  - DRUG: drug_delivery_activate = 1, iv_line_setup = 1, drug_dosage = latched dose.
  - FLUSH: saline_flush = 1, iv_line_setup = 1.
  - CLOSE: iv_line_setup = 1.
  - IDLE and LOCKOUT: all drives 0.
- brady and tachy are mutually exclusive by construction (HR_LOW ≤ HR_HIGH is required).
- A tachy_q that arrives during the sequence is ignored. Re-trigger requires tachy_q while in IDLE.
- The tachy counter keeps counting during LOCKOUT. Persistent tachycardia therefore re-enters DRUG on the cycle after LOCKOUT → IDLE.

## Timing
- Reset (rst_n low, asynchronous): all outputs 0, state IDLE, both run counters 0, dose_count 0.
- Trigger latency: with the condition first sampled true at edge 1, outputs assert at edge PERSIST_CYC.
- Drug sequence: each stage is exactly *_CYC cycles. The full dose cycle is DRUG_CYC + FLUSH_CYC + CLOSE_CYC + LOCKOUT_CYC = 16 cycles at the defaults.
- CPR deassert: 1 cycle after brady is sampled false.
- Reset mid-sequence: all drives fall to 0 immediately and asynchronously.
- Preemption by CPR: at that edge, drug_dosage, drug_delivery_activate, saline_flush and iv_line_setup drop to 0 and cpr_activate rises.

## Configuration
- CARDIAC_DOSE_ESCALATION_EN defined: dose = DOSE_FIRST + dose_count × DOSE_STEP, saturating at 15. Defaults give 6 then 12.
- Undefined: every dose = DOSE_FIRST.

## Structure
- Package cardiac_therapy_pkg holds:
  - the state enum;
  - the default threshold and timing constants;
  - the dose saturation function.
- Sub-module persistence_filter: one consecutive-cycle qualifier with parameter PERSIST_CYC, instantiated twice (brady, tachy).
- One stage counter, width $clog2 of the largest *_CYC + 1, reloaded on each state change.

## Test plan
- Bradycardia: HR=40, SpO2=90, valid for 6 cycles → cpr_activate rises at the 4th edge, falls 1 cycle after HR=70.
- Glitch rejection: HR=130, SpO2=98, valid for 3 cycles then HR=80 → no output. The same stimulus for 4 cycles → DRUG with drug_dosage=6.
- Full sequence: sustained tachy → DRUG 2 cycles, FLUSH 2 cycles, CLOSE 4 cycles, LOCKOUT 8 cycles. Second dose is 12 with the macro defined, 6 without. Then therapy_exhausted=1, dose_count=2, and no third dose.
- Preemption: switch to HR=40, SpO2=90 mid-FLUSH → after 4 cycles saline_flush=0, iv_line_setup=0, cpr_activate=1, dose_count=0, therapy_exhausted=0.
- Invalid ECG: HR=30, SpO2=80, valid=0 → no output. Toggling valid off for 1 cycle restarts the persistence count.
- Reset: assert rst_n=0 during DRUG → all outputs 0 asynchronously. After release, behaviour matches a fresh start.
